// File: rtl/vliw_decode_stage_pkg.sv
// rtl/vliw_decode_stage_pkg.sv - shared constants, predicate encodings and predicate evaluation
package vliw_decode_stage_pkg;

  localparam int OP_W   = 5;
  localparam int PRED_W = 2;

  localparam logic [OP_W-1:0] OP_JMP = 5'b01001;

  // Predicate condition registers
  localparam int R_COND0 = 30;
  localparam int R_COND1 = 31;

  typedef enum logic [PRED_W-1:0] {
    PRED_ALWAYS = 2'b00,
    PRED_C0     = 2'b01,
    PRED_C1     = 2'b10,
    PRED_ANY    = 2'b11
  } pred_e;

  function automatic logic pred_true(pred_e pred, logic c0_nz, logic c1_nz);
    logic r;
    case (pred)
      PRED_ALWAYS: r = 1'b1;
      PRED_C0:     r = c0_nz;
      PRED_C1:     r = c1_nz;
      default:     r = c0_nz | c1_nz;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vliw_decode_stage_if.sv
// rtl/vliw_decode_stage_if.sv - fetch-side handshake and ID/EX register outputs of the decode stage
// Signals:
//   id_valid/id_instr/flush  fetch bundle and squash, driven by master
//   id_stall                 bundle not accepted this cycle
//   x_*                      ID/EX pipeline register contents
interface vliw_decode_stage_if
  import vliw_decode_stage_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 16,
  parameter int RA_W      = 5,
  parameter int INSTR_W   = 22
);
  logic                        id_valid;
  logic [NUM_SLOTS*INSTR_W-1:0] id_instr;
  logic                        id_stall;
  logic                        flush;
  logic                        x_valid;
  logic [NUM_SLOTS*OP_W-1:0]   x_op;
  logic [NUM_SLOTS*DATA_W-1:0] x_src0;
  logic [NUM_SLOTS*DATA_W-1:0] x_src1;
  logic [NUM_SLOTS*RA_W-1:0]   x_rd;
  logic [NUM_SLOTS-1:0]        x_cnd;
  logic                        x_pred_rw;

  modport master (
    output id_valid, id_instr, flush,
    input  id_stall, x_valid, x_op, x_src0, x_src1, x_rd, x_cnd, x_pred_rw
  );

  modport slave (
    input  id_valid, id_instr, flush,
    output id_stall, x_valid, x_op, x_src0, x_src1, x_rd, x_cnd, x_pred_rw
  );
endinterface

// File: rtl/vliw_decode_stage_regfile.sv
// rtl/vliw_decode_stage_regfile.sv - register file, NUM_RD async read ports, NUM_SLOTS sync write ports
// Ports:
//   clk                          write clock (contents are never reset)
//   wb_en_i/wb_tag_i/wb_data_i   per-slot write ports, highest slot wins on a shared tag
//   rd_tag_i/rd_data_o           flattened read ports; r0 reads 0
// Optional macro REGFILE_BYPASS_EN: a read of a register written this cycle returns the write data.
module vliw_regfile #(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 16,
  parameter int RA_W      = 5,
  parameter int NUM_RD    = 8
) (
  input  logic                        clk,
  input  logic [NUM_SLOTS-1:0]        wb_en_i,
  input  logic [NUM_SLOTS*RA_W-1:0]   wb_tag_i,
  input  logic [NUM_SLOTS*DATA_W-1:0] wb_data_i,
  input  logic [NUM_RD*RA_W-1:0]      rd_tag_i,
  output logic [NUM_RD*DATA_W-1:0]    rd_data_o
);
  logic [DATA_W-1:0] mem_q [0:(1<<RA_W)-1];

  // Ascending slot order makes the highest slot's write the last one to land.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wb_en_i[s] && (wb_tag_i[s*RA_W +: RA_W] != '0)) begin
        mem_q[wb_tag_i[s*RA_W +: RA_W]] <= wb_data_i[s*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [RA_W-1:0]   tag;
    logic [DATA_W-1:0] val;
    assign tag = rd_tag_i[r*RA_W +: RA_W];

    always_comb begin
      val = mem_q[tag];
`ifdef REGFILE_BYPASS_EN
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (wb_en_i[s] && (wb_tag_i[s*RA_W +: RA_W] == tag)) begin
          val = wb_data_i[s*DATA_W +: DATA_W];
        end
      end
`endif
      if (tag == '0) begin
        val = '0;
      end
    end

    assign rd_data_o[r*DATA_W +: DATA_W] = val;
  end

endmodule

// File: rtl/vliw_decode_stage.sv
// rtl/vliw_decode_stage.sv - VLIW decode stage: operand read, EX/MEM forwarding, load-use stall, predicates
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   bus (slave)                  fetch bundle in, id_stall out, ID/EX register x_* out
//   wb_en/wb_tag/wb_data         regfile write ports
//   ex_en/ex_is_load/ex_tag/ex_data   EX forwarding source (loads cause a stall)
//   mem_en/mem_tag/mem_data      MEM forwarding source
// Optional macro REGFILE_BYPASS_EN (regfile write-through, see vliw_regfile).
module vliw_decode_stage
  import vliw_decode_stage_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 16,
  parameter int RA_W      = 5,
  parameter int INSTR_W   = 22
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vliw_decode_stage_if.slave          bus,
  input  logic [NUM_SLOTS-1:0]        wb_en,
  input  logic [NUM_SLOTS*RA_W-1:0]   wb_tag,
  input  logic [NUM_SLOTS*DATA_W-1:0] wb_data,
  input  logic [NUM_SLOTS-1:0]        ex_en,
  input  logic [NUM_SLOTS-1:0]        ex_is_load,
  input  logic [NUM_SLOTS*RA_W-1:0]   ex_tag,
  input  logic [NUM_SLOTS*DATA_W-1:0] ex_data,
  input  logic [NUM_SLOTS-1:0]        mem_en,
  input  logic [NUM_SLOTS*RA_W-1:0]   mem_tag,
  input  logic [NUM_SLOTS*DATA_W-1:0] mem_data
);
  localparam int RS0_LSB  = OP_W;
  localparam int RS1_LSB  = OP_W + RA_W;
  localparam int RD_LSB   = OP_W + 2*RA_W;
  localparam int PRED_LSB = OP_W + 3*RA_W;
  localparam int NUM_SRC  = 2*NUM_SLOTS;
  // Two extra read ports resolve the predicate registers r30/r31.
  localparam int NUM_RD   = NUM_SRC + 2;

  logic [NUM_SRC*RA_W-1:0]   src_tag;
  logic [NUM_RD*RA_W-1:0]    rd_tag;
  logic [NUM_RD*DATA_W-1:0]  rf_data;
  logic [NUM_RD*DATA_W-1:0]  res;
  logic [NUM_SRC-1:0]        load_hit;
  logic                      accept;
  logic                      c0_nz, c1_nz;

  logic                        x_valid_q,   x_valid_d;
  logic [NUM_SLOTS*OP_W-1:0]   x_op_q,      x_op_d;
  logic [NUM_SLOTS*DATA_W-1:0] x_src0_q,    x_src0_d;
  logic [NUM_SLOTS*DATA_W-1:0] x_src1_q,    x_src1_d;
  logic [NUM_SLOTS*RA_W-1:0]   x_rd_q,      x_rd_d;
  logic [NUM_SLOTS-1:0]        x_cnd_q,     x_cnd_d;
  logic                        x_pred_rw_q, x_pred_rw_d;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_tag
    assign src_tag[(2*s)*RA_W   +: RA_W] = bus.id_instr[s*INSTR_W + RS0_LSB +: RA_W];
    assign src_tag[(2*s+1)*RA_W +: RA_W] = bus.id_instr[s*INSTR_W + RS1_LSB +: RA_W];
  end

  assign rd_tag = {RA_W'(R_COND1), RA_W'(R_COND0), src_tag};

  vliw_regfile #(
    .NUM_SLOTS (NUM_SLOTS),
    .DATA_W    (DATA_W),
    .RA_W      (RA_W),
    .NUM_RD    (NUM_RD)
  ) u_regfile (
    .clk       (clk),
    .wb_en_i   (wb_en),
    .wb_tag_i  (wb_tag),
    .wb_data_i (wb_data),
    .rd_tag_i  (rd_tag),
    .rd_data_o (rf_data)
  );

  // Forwarding: MEM applied first so EX overrides it; ascending slot loops let the highest slot win.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_fwd
    logic [RA_W-1:0]   tag;
    logic [DATA_W-1:0] val;
    assign tag = rd_tag[p*RA_W +: RA_W];

    always_comb begin
      val = rf_data[p*DATA_W +: DATA_W];
      for (int e = 0; e < NUM_SLOTS; e++) begin
        if (mem_en[e] && (mem_tag[e*RA_W +: RA_W] == tag)) val = mem_data[e*DATA_W +: DATA_W];
      end
      for (int e = 0; e < NUM_SLOTS; e++) begin
        if (ex_en[e] && !ex_is_load[e] && (ex_tag[e*RA_W +: RA_W] == tag))
          val = ex_data[e*DATA_W +: DATA_W];
      end
      if (tag == '0) val = '0;
    end

    assign res[p*DATA_W +: DATA_W] = val;
  end

  for (genvar q = 0; q < NUM_SRC; q++) begin : g_haz
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int e = 0; e < NUM_SLOTS; e++) begin
        if (ex_en[e] && ex_is_load[e] && (ex_tag[e*RA_W +: RA_W] == src_tag[q*RA_W +: RA_W]))
          hit = 1'b1;
      end
      if (src_tag[q*RA_W +: RA_W] == '0) hit = 1'b0;
    end
    assign load_hit[q] = hit;
  end

  // Gated by rst_n so the stall output is quiet while reset is held.
  assign bus.id_stall = rst_n & bus.id_valid & ~bus.flush & (|load_hit);
  assign accept       = bus.id_valid & ~bus.flush & ~(|load_hit);

  assign c0_nz = |res[NUM_SRC*DATA_W     +: DATA_W];
  assign c1_nz = |res[(NUM_SRC+1)*DATA_W +: DATA_W];

  always_comb begin
    x_valid_d   = 1'b0;
    x_op_d      = '0;
    x_src0_d    = '0;
    x_src1_d    = '0;
    x_rd_d      = '0;
    x_cnd_d     = '0;
    x_pred_rw_d = 1'b0;
    if (accept) begin
      x_valid_d = 1'b1;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        x_op_d[s*OP_W +: OP_W]       = bus.id_instr[s*INSTR_W +: OP_W];
        x_rd_d[s*RA_W +: RA_W]       = bus.id_instr[s*INSTR_W + RD_LSB +: RA_W];
        x_src0_d[s*DATA_W +: DATA_W] = res[(2*s)*DATA_W +: DATA_W];
        x_src1_d[s*DATA_W +: DATA_W] = res[(2*s+1)*DATA_W +: DATA_W];
        x_cnd_d[s] = pred_true(pred_e'(bus.id_instr[s*INSTR_W + PRED_LSB +: PRED_W]), c0_nz, c1_nz);
      end
      x_pred_rw_d = (bus.id_instr[OP_W-1:0] == OP_JMP) && x_cnd_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid_q   <= 1'b0;
      x_op_q      <= '0;
      x_src0_q    <= '0;
      x_src1_q    <= '0;
      x_rd_q      <= '0;
      x_cnd_q     <= '0;
      x_pred_rw_q <= 1'b0;
    end else begin
      x_valid_q   <= x_valid_d;
      x_op_q      <= x_op_d;
      x_src0_q    <= x_src0_d;
      x_src1_q    <= x_src1_d;
      x_rd_q      <= x_rd_d;
      x_cnd_q     <= x_cnd_d;
      x_pred_rw_q <= x_pred_rw_d;
    end
  end

  assign bus.x_valid   = x_valid_q;
  assign bus.x_op      = x_op_q;
  assign bus.x_src0    = x_src0_q;
  assign bus.x_src1    = x_src1_q;
  assign bus.x_rd      = x_rd_q;
  assign bus.x_cnd     = x_cnd_q;
  assign bus.x_pred_rw = x_pred_rw_q;

endmodule
